// File: rtl/synth_pkg.sv
// Shared types and constants for the synthesiser voice path: waveform select,
// oscillator latency and the quarter-wave sine table generator.
package synth_pkg;

  typedef enum logic [1:0] {
    WAVE_SINE     = 2'd0,
    WAVE_SAW      = 2'd1,
    WAVE_SQUARE   = 2'd2,
    WAVE_TRIANGLE = 2'd3
  } waveform_t;

  localparam int unsigned WAVETABLE_LATENCY = 2;

  localparam real SYNTH_PI = 3.14159265358979323846;

  // Half-step offset keeps the quarter-wave mirror exact and never reaches -full-scale.
  function automatic int sine_rom_entry(input int unsigned k,
                                        input int unsigned table_bits,
                                        input int unsigned out_width);
    real amp;
    real ang;
    amp = (2.0 ** real'(out_width - 1)) - 1.0;
    ang = (SYNTH_PI / 2.0) * (real'(k) + 0.5) / (2.0 ** real'(table_bits - 2));
    return $rtoi(amp * $sin(ang) + 0.5);
  endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// Quarter-wave sine table, synchronous read with one cycle of latency.
// Contents are elaboration-time constants so the read maps onto block ROM.
module sine_quarter_rom
  import synth_pkg::*;
#(
  parameter int unsigned TABLE_BITS = 10,
  parameter int unsigned OUT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [TABLE_BITS-3:0] addr,
  output logic [OUT_WIDTH-1:0]  data
);

  localparam int unsigned DEPTH = 2 ** (TABLE_BITS - 2);

  logic [OUT_WIDTH-1:0] w_rom [DEPTH];
  logic [OUT_WIDTH-1:0] r_data;

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    assign w_rom[k] = OUT_WIDTH'(sine_rom_entry(k, TABLE_BITS, OUT_WIDTH));
  end

  always_ff @(posedge clk) begin
    if (en) begin
      r_data <= w_rom[addr];
    end
  end

  assign data = r_data;

endmodule

// File: rtl/wavetable_oscillator.sv
// Phase-accumulator oscillator producing sine/saw/square/triangle samples
// with a fixed two-cycle latency and a single-cycle valid strobe per sample.
module wavetable_oscillator
  import synth_pkg::*;
#(
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned TABLE_BITS = 10,
  parameter int unsigned OUT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_en,
  input  logic [ACC_WIDTH-1:0] increment,
  input  logic [1:0]           waveform,
  input  logic                 phase_reset,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] q
);

  localparam int unsigned QW = TABLE_BITS - 2;
  localparam logic [OUT_WIDTH-1:0] POS_FULL = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] NEG_FULL = {1'b1, {(OUT_WIDTH-2){1'b0}}, 1'b1};

  logic [ACC_WIDTH-1:0] r_acc;
  logic [ACC_WIDTH-1:0] w_phase;
  logic [QW-1:0]        w_rom_addr;
  logic [OUT_WIDTH-1:0] w_rom_data;

  logic                 r_valid0;
  logic [OUT_WIDTH:0]   r_p0;
  waveform_t            r_wave0;

  logic [OUT_WIDTH-1:0] w_tri_u;
  logic [OUT_WIDTH-1:0] w_sample;

  logic                 r_valid;
  logic [OUT_WIDTH-1:0] r_q;

  assign w_phase = phase_reset ? '0 : r_acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
    end else if (phase_reset) begin
      r_acc <= sample_en ? increment : '0;
    end else if (sample_en) begin
      r_acc <= r_acc + increment;
    end
  end

  // ROM address comes straight from the live phase so the ROM's own read
  // register doubles as stage 0, keeping the total latency at two.
  assign w_rom_addr = w_phase[ACC_WIDTH-2] ? ~w_phase[ACC_WIDTH-3 -: QW]
                                           :  w_phase[ACC_WIDTH-3 -: QW];

  sine_quarter_rom #(
    .TABLE_BITS (TABLE_BITS),
    .OUT_WIDTH  (OUT_WIDTH)
  ) u_rom (
    .clk  (clk),
    .en   (sample_en),
    .addr (w_rom_addr),
    .data (w_rom_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid0 <= 1'b0;
      r_p0     <= '0;
      r_wave0  <= WAVE_SINE;
    end else begin
      r_valid0 <= sample_en;
      if (sample_en) begin
        r_p0    <= w_phase[ACC_WIDTH-1 -: OUT_WIDTH+1];
        r_wave0 <= waveform_t'(waveform);
      end
    end
  end

  assign w_tri_u = r_p0[OUT_WIDTH-1:0] ^ {OUT_WIDTH{r_p0[OUT_WIDTH]}};

  always_comb begin
    w_sample = '0;
    case (r_wave0)
      WAVE_SINE:     w_sample = r_p0[OUT_WIDTH] ? -w_rom_data : w_rom_data;
      WAVE_SAW:      w_sample = {~r_p0[OUT_WIDTH], r_p0[OUT_WIDTH-1:1]};
      WAVE_SQUARE:   w_sample = r_p0[OUT_WIDTH] ? NEG_FULL : POS_FULL;
      WAVE_TRIANGLE: w_sample = {~w_tri_u[OUT_WIDTH-1], w_tri_u[OUT_WIDTH-2:0]};
      default:       w_sample = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_q     <= '0;
    end else begin
      r_valid <= r_valid0;
      if (r_valid0) begin
        r_q <= w_sample;
      end
    end
  end

  assign out_valid = r_valid;
  assign q         = r_q;

endmodule
